// File: rtl/cic_interpolator.sv
// CIC interpolator: comb chain at the input rate, zero-stuffing upsampler, integrator chain at the clock rate.
// Optional macro CIC_INTERP_HOLD_EN: on underflow re-use the last accepted sample instead of zero.
module cic_interpolator #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int RATE   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             underflow
);

  localparam int LOG2R = $clog2(RATE);
  localparam int RW    = WIDTH + STAGES * LOG2R;
  localparam int SHIFT = (STAGES - 1) * LOG2R;

  // Handshake: a sample transfers on a cycle where in_valid and in_ready are both high.
  // in_ready is high only at phase 0 and never while rst is asserted; in/in_valid are
  // ignored on every other cycle.

  logic [LOG2R-1:0] ph;
  logic             running;
  logic [RW-1:0]    d [1:STAGES];
  logic [RW-1:0]    a [1:STAGES];
  logic [RW-1:0]    c_in [1:STAGES];
  logic [RW-1:0]    acc;
  logic [RW-1:0]    comb_out;
  logic [RW-1:0]    u;
  logic [RW-1:0]    s_ext;
  logic [RW-1:0]    shifted;
  logic [WIDTH-1:0] sample;
  logic             accept;
  logic             load;

  assign in_ready  = (ph == '0) && !rst;
  assign accept    = in_ready && in_valid;
  assign load      = in_ready && (in_valid || running);
  assign underflow = in_ready && running && !in_valid;
  assign out_valid = running;

`ifdef CIC_INTERP_HOLD_EN
  logic [WIDTH-1:0] hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (accept) begin
      hold <= in;
    end
  end

  assign sample = in_valid ? in : hold;
`else
  assign sample = in_valid ? in : '0;
`endif

  assign s_ext = {{(RW - WIDTH){1'b0}}, sample};

  // c_in[k] is the value entering comb stage k; it becomes that stage's delay on a load.
  always_comb begin
    acc = s_ext;
    for (int k = 1; k <= STAGES; k++) begin
      c_in[k] = acc;
      acc     = acc - d[k];
    end
    comb_out = acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph      <= '0;
      running <= 1'b0;
      u       <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        d[k] <= '0;
        a[k] <= '0;
      end
    end else begin
      if (accept) begin
        running <= 1'b1;
      end
      // RATE is a power of two, so the natural wrap of ph gives RATE-1 -> 0.
      if (running || accept) begin
        ph <= ph + LOG2R'(1);
      end
      if (load) begin
        for (int k = 1; k <= STAGES; k++) begin
          d[k] <= c_in[k];
        end
      end
      u    <= load ? comb_out : '0;
      a[1] <= a[1] + u;
      for (int k = 2; k <= STAGES; k++) begin
        a[k] <= a[k] + a[k-1];
      end
    end
  end

  // Integrator gain is RATE^(STAGES-1); shifting it out gives unity DC gain.
  assign shifted = a[STAGES] >> SHIFT;
  assign out     = shifted[WIDTH-1:0];

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator: three parameter sets driven from the same clock and reset.
module tb_cic_interpolator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance: WIDTH=8, STAGES=2, RATE=4
  logic [7:0] in2, out2;
  logic       v2, rdy2, ov2, uf2;
  // STAGES=1, RATE=4
  logic [7:0] in1, out1;
  logic       v1, rdy1, ov1, uf1;
  // STAGES=3, RATE=8
  logic [7:0] in3, out3;
  logic       v3, rdy3, ov3, uf3;

  cic_interpolator #(.WIDTH(8), .STAGES(2), .RATE(4)) dut2 (
    .clk(clk), .rst(rst), .in(in2), .in_valid(v2), .in_ready(rdy2),
    .out(out2), .out_valid(ov2), .underflow(uf2)
  );
  cic_interpolator #(.WIDTH(8), .STAGES(1), .RATE(4)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .in_valid(v1), .in_ready(rdy1),
    .out(out1), .out_valid(ov1), .underflow(uf1)
  );
  cic_interpolator #(.WIDTH(8), .STAGES(3), .RATE(8)) dut3 (
    .clk(clk), .rst(rst), .in(in3), .in_valid(v3), .in_ready(rdy3),
    .out(out3), .out_valid(ov3), .underflow(uf3)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] din;
    logic       vld;
    int         exp_out;
    logic       exp_ov;
    logic       exp_rdy;
    logic       exp_uf;
  } vec_t;

  vec_t tab_a [16];
  vec_t tab_c [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of dut2 stimulus just after a falling edge, then check its outputs.
  task automatic apply(input string tag, input int idx, input vec_t v);
    in2 = v.din;
    v2  = v.vld;
    #1;
    chk($sformatf("%s[%0d] out", tag, idx), 32'(out2), 32'(v.exp_out));
    chk($sformatf("%s[%0d] out_valid", tag, idx), 32'(ov2), 32'(v.exp_ov));
    chk($sformatf("%s[%0d] in_ready", tag, idx), 32'(rdy2), 32'(v.exp_rdy));
    chk($sformatf("%s[%0d] underflow", tag, idx), 32'(uf2), 32'(v.exp_uf));
  endtask

  initial begin
    int ea [16];
    int ec [32];
    vec_t v;

    // 100 at slots 0 and 4, 200 from slot 8; 77 offered off-slot must be ignored.
    ea = '{0, 0, 0, 25, 50, 75, 100, 100, 100, 100, 100, 125, 150, 175, 200, 200};
    for (int k = 0; k < 16; k++) begin
      tab_a[k].din     = ((k % 4) == 0) ? ((k < 8) ? 8'd100 : 8'd200) : 8'd77;
      tab_a[k].vld     = (k != 2);
      tab_a[k].exp_out = ea[k];
      tab_a[k].exp_ov  = (k >= 1);
      tab_a[k].exp_rdy = ((k % 4) == 0);
      tab_a[k].exp_uf  = 1'b0;
    end

    // Idle two cycles, stream 50 from p2, skip the slot at p18 and one off-slot cycle.
    ec = '{0, 0, 0, 0, 0, 12, 25, 37, 50, 50, 50, 50, 50, 50, 50, 50,
           50, 50, 50, 50, 50, 37, 25, 12, 0, 12, 25, 37, 50, 50, 50, 50};
`ifdef CIC_INTERP_HOLD_EN
    for (int p = 21; p <= 27; p++) ec[p] = 50;
`endif
    for (int p = 0; p < 32; p++) begin
      tab_c[p].din     = 8'd50;
      tab_c[p].vld     = !(p == 0 || p == 1 || p == 18 || p == 19);
      tab_c[p].exp_out = ec[p];
      tab_c[p].exp_ov  = (p >= 3);
      tab_c[p].exp_rdy = (p < 2) || (((p - 2) % 4) == 0);
      tab_c[p].exp_uf  = (p == 18);
    end

    in2 = 8'd0;   v2 = 1'b0;
    in1 = 8'd100; v1 = 1'b1;
    in3 = 8'd255; v3 = 1'b1;

    #2 rst = 1'b1;
    #1;
    chk("reset out2", 32'(out2), 0);
    chk("reset out_valid2", 32'(ov2), 0);
    chk("reset in_ready2", 32'(rdy2), 0);
    chk("reset underflow2", 32'(uf2), 0);
    chk("reset out1", 32'(out1), 0);
    chk("reset in_ready3", 32'(rdy3), 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 48; k++) begin
      if (k < 16) begin
        apply("ramp", k, tab_a[k]);
      end else begin
        v = '{8'd200, 1'b1, 200, 1'b1, ((k % 4) == 0), 1'b0};
        apply("steady", k, v);
      end
      chk($sformatf("s1[%0d] out", k), 32'(out1), (k >= 2) ? 32'd100 : 32'd0);
      chk($sformatf("s1[%0d] in_ready", k), 32'(rdy1), 32'((k % 4) == 0));
      chk($sformatf("s3[%0d] in_ready", k), 32'(rdy3), 32'((k % 8) == 0));
      if (k == 3) chk("s3 latency out@3", 32'(out3), 0);
      if (k == 4) chk("s3 first out@4", 32'(out3), 3);
      if (k >= 40) chk($sformatf("s3[%0d] settled", k), 32'(out3), 255);
      @(negedge clk);
    end

    rst = 1'b1;
    #1;
    chk("midrst out2", 32'(out2), 0);
    chk("midrst out_valid2", 32'(ov2), 0);
    chk("midrst in_ready2", 32'(rdy2), 0);
    chk("midrst underflow2", 32'(uf2), 0);
    chk("midrst out1", 32'(out1), 0);
    chk("midrst out3", 32'(out3), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int p = 0; p < 32; p++) begin
      apply("restart", p, tab_c[p]);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
